// File: rtl/simd_pkg.sv
// Shared definitions for the SIMD ALU pipeline: opcode width and opcode values.
package simd_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'd0;  // wrapping add
    localparam logic [OP_W-1:0] OP_SUB   = 3'd1;  // wrapping subtract a-b
    localparam logic [OP_W-1:0] OP_ADDUS = 3'd2;  // unsigned saturating add
    localparam logic [OP_W-1:0] OP_SUBUS = 3'd3;  // unsigned saturating subtract, floor 0
    localparam logic [OP_W-1:0] OP_ADDSS = 3'd4;  // signed saturating add
    localparam logic [OP_W-1:0] OP_SUBSS = 3'd5;  // signed saturating subtract
    localparam logic [OP_W-1:0] OP_MAXU  = 3'd6;  // unsigned maximum
    localparam logic [OP_W-1:0] OP_MINU  = 3'd7;  // unsigned minimum

endpackage

// File: rtl/simd_lane.sv
// One combinational ALU lane.
// Ports: op (operation), en (lane mask bit), a/b (operands) -> y (result), sat (result was clamped).
// A disabled lane passes a through with sat=0.
module simd_lane
    import simd_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             sat
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic             ovf_add_s;
    logic             ovf_sub_s;
    logic [WIDTH-1:0] s_max;
    logic [WIDTH-1:0] s_min;
    logic [WIDTH-1:0] s_clamp;

    // One extra bit holds the unsigned carry (add) or borrow (sub).
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    // Signed overflow: result sign disagrees with a when the operation could not change it.
    assign ovf_add_s = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    assign ovf_sub_s = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);

    assign s_max   = {1'b0, {(WIDTH-1){1'b1}}};
    assign s_min   = {1'b1, {(WIDTH-1){1'b0}}};
    // On signed overflow the true result lies on the side of a's sign.
    assign s_clamp = a[MSB] ? s_min : s_max;

    // Per-operation result and clamp flag.
    always_comb begin
        y   = a;
        sat = 1'b0;
        if (en) begin
            case (op)
                OP_ADD:   y = sum[WIDTH-1:0];
                OP_SUB:   y = dif[WIDTH-1:0];
                OP_ADDUS: begin
                    sat = sum[WIDTH];
                    y   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                end
                OP_SUBUS: begin
                    sat = dif[WIDTH];
                    y   = dif[WIDTH] ? {WIDTH{1'b0}} : dif[WIDTH-1:0];
                end
                OP_ADDSS: begin
                    sat = ovf_add_s;
                    y   = ovf_add_s ? s_clamp : sum[WIDTH-1:0];
                end
                OP_SUBSS: begin
                    sat = ovf_sub_s;
                    y   = ovf_sub_s ? s_clamp : dif[WIDTH-1:0];
                end
                OP_MAXU:  y = (a >= b) ? a : b;
                OP_MINU:  y = (a <= b) ? a : b;
                default:  y = a;
            endcase
        end
    end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage pipelined SIMD ALU with valid/ready handshakes on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_op/in_mask/in_a/in_b (operand bundle);
//        out_valid/out_ready/out_y/out_sat (result bundle); sat_sticky/sat_clear (saturation history).
// Stage 1 registers the operand bundle, stage 2 registers the lane results.
module simd_alu_pipe
    import simd_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [LANES-1:0]       in_mask,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_y,
    output logic [LANES-1:0]       out_sat,
    output logic                   sat_sticky,
    input  logic                   sat_clear
);

    logic                   s1_valid;
    logic [OP_W-1:0]        s1_op;
    logic [LANES-1:0]       s1_mask;
    logic [LANES*WIDTH-1:0] s1_a;
    logic [LANES*WIDTH-1:0] s1_b;

    logic                   adv1;
    logic                   adv2;
    logic [LANES*WIDTH-1:0] lane_y;
    logic [LANES-1:0]       lane_sat;

    // Stage 2 may load when empty or being drained; stage 1 when empty or stage 2 moves.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // Lane array; lanes share nothing, so no carry crosses a lane boundary.
    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        simd_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .op  (s1_op),
            .en  (s1_mask[i]),
            .a   (s1_a[i*WIDTH +: WIDTH]),
            .b   (s1_b[i*WIDTH +: WIDTH]),
            .y   (lane_y[i*WIDTH +: WIDTH]),
            .sat (lane_sat[i])
        );
    end

    // Stage 1 payload; only loads on an actual transfer, otherwise holds (possibly stale).
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_op   <= in_op;
            s1_mask <= in_mask;
            s1_a    <= in_a;
            s1_b    <= in_b;
        end
    end

    // Stage valids and stage 2 result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_sat   <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
            end
            if (adv2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_y   <= lane_y;
                    out_sat <= lane_sat;
                end
            end
        end
    end

    // Saturation history: set only when a clamped bundle is actually taken; clear dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_sticky <= 1'b0;
        end else if (sat_clear) begin
            sat_sticky <= 1'b0;
        end else if (out_valid && out_ready && (|out_sat)) begin
            sat_sticky <= 1'b1;
        end
    end

endmodule
